// File: rtl/riscv_rf_pkg.sv
// Shared types for the register-file access scheduler.
package riscv_rf_pkg;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } sched_state_e;
endpackage

// File: rtl/reg_access_sched_wb_rr_arb.sv
// Two-requester round-robin arbiter for the register-file write port.
// req[0]/gnt[0] = ALU writeback, req[1]/gnt[1] = MEM writeback.
module wb_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // ptr_q = 0: ALU has priority; ptr_q = 1: MEM has priority
  logic ptr_q;

  // Priority pick; nothing is granted while reset is asserted
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (!ptr_q) begin
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
      end else begin
        if (req[1])      gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
      end
    end
  end

  // Pointer moves past the winner, only when something was granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr_q <= 1'b0;
    else if (gnt[0]) ptr_q <= 1'b1;
    else if (gnt[1]) ptr_q <= 1'b0;
  end
endmodule

// File: rtl/reg_access_sched.sv
// Register-file access scheduler: operand read sequencing, writeback
// arbitration and a per-register busy scoreboard (RAW / WAW stalls).
// Optional feature: define REG_SCHED_BYPASS_EN to forward a writeback granted
// in the issue cycle straight into the operand, saving one cycle per RAW release.
module reg_access_sched
  import riscv_rf_pkg::*;
#(
  parameter int D_WIDTH  = 32,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [REG_AW-1:0]  iss_rs1,
  input  logic [REG_AW-1:0]  iss_rs2,
  input  logic [REG_AW-1:0]  iss_rd,
  input  logic               iss_rd_we,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [D_WIDTH-1:0] op_rs1_dat,
  output logic [D_WIDTH-1:0] op_rs2_dat,
  input  logic               alu_wb_valid,
  input  logic [REG_AW-1:0]  alu_wb_rd,
  input  logic [D_WIDTH-1:0] alu_wb_dat,
  output logic               alu_wb_ready,
  input  logic               mem_wb_valid,
  input  logic [REG_AW-1:0]  mem_wb_rd,
  input  logic [D_WIDTH-1:0] mem_wb_dat,
  output logic               mem_wb_ready,
  output logic [REG_AW-1:0]  rf_rs1,
  output logic [REG_AW-1:0]  rf_rs2,
  output logic               rf_ld,
  input  logic [D_WIDTH-1:0] rf_rs1Out,
  input  logic [D_WIDTH-1:0] rf_rs2Out,
  output logic [REG_AW-1:0]  rf_rd,
  output logic               rf_str,
  output logic [D_WIDTH-1:0] rf_WBDat
);
  sched_state_e          state_q, state_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [1:0]            gnt;
  logic                  wb_fire;
  logic [REG_AW-1:0]     wb_rd;
  logic [D_WIDTH-1:0]    wb_dat;
  logic                  rs1_hz, rs2_hz, rd_hz, accept;
  logic [REG_AW-1:0]     rs1_q, rs2_q;
  logic                  op_valid_q;
`ifdef REG_SCHED_BYPASS_EN
  logic                  byp1, byp2;
  logic                  byp1_q, byp2_q;
  logic [D_WIDTH-1:0]    byp1_dat_q, byp2_dat_q;
`endif

  wb_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req ({mem_wb_valid, alu_wb_valid}),
    .gnt (gnt)
  );

  // Writeback mux onto the single register-file write port; x0 writes are dropped
  always_comb begin
    wb_fire      = |gnt;
    wb_rd        = gnt[1] ? mem_wb_rd  : alu_wb_rd;
    wb_dat       = gnt[1] ? mem_wb_dat : alu_wb_dat;
    alu_wb_ready = gnt[0];
    mem_wb_ready = gnt[1];
    rf_rd        = wb_rd;
    rf_WBDat     = wb_dat;
    rf_str       = wb_fire && (wb_rd != '0);
  end

  // Hazard detection from the registered scoreboard; x0 is never busy
  always_comb begin
    rs1_hz = busy_q[iss_rs1] && (iss_rs1 != '0);
    rs2_hz = busy_q[iss_rs2] && (iss_rs2 != '0);
    rd_hz  = iss_rd_we && busy_q[iss_rd] && (iss_rd != '0);
`ifdef REG_SCHED_BYPASS_EN
    byp1   = wb_fire && (wb_rd == iss_rs1) && (iss_rs1 != '0);
    byp2   = wb_fire && (wb_rd == iss_rs2) && (iss_rs2 != '0);
    rs1_hz = rs1_hz && !byp1;
    rs2_hz = rs2_hz && !byp2;
`endif
    accept    = !rst && (state_q == IDLE) && iss_valid && !(rs1_hz || rs2_hz || rd_hz);
    iss_ready = accept;
    rf_ld     = accept;
    rf_rs1    = iss_rs1;
    rf_rs2    = iss_rs2;
  end

  // Scoreboard next value: clear on writeback, set on accepted writer; set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_fire) busy_d[wb_rd] = 1'b0;
    if (accept && iss_rd_we && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // FSM next state: IDLE -> READ -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = RESP;
      RESP:    if (op_valid_q && op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, scoreboard, operand valid, latched source indices
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= '0;
      op_valid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (accept) begin
        rs1_q <= iss_rs1;
        rs2_q <= iss_rs2;
      end
      if (state_q == READ)                           op_valid_q <= 1'b1;
      else if (state_q == RESP && op_valid_q && op_ready) op_valid_q <= 1'b0;
    end
  end

`ifdef REG_SCHED_BYPASS_EN
  // Capture writeback data granted in the accept cycle, per source
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp1_dat_q <= '0;
      byp2_dat_q <= '0;
    end else if (accept) begin
      byp1_q     <= byp1;
      byp2_q     <= byp2;
      byp1_dat_q <= wb_dat;
      byp2_dat_q <= wb_dat;
    end
  end
`endif

  // Operand capture in READ; held stable through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_rs1_dat <= '0;
      op_rs2_dat <= '0;
    end else if (state_q == READ) begin
`ifdef REG_SCHED_BYPASS_EN
      op_rs1_dat <= (rs1_q == '0) ? '0 : (byp1_q ? byp1_dat_q : rf_rs1Out);
      op_rs2_dat <= (rs2_q == '0) ? '0 : (byp2_q ? byp2_dat_q : rf_rs2Out);
`else
      op_rs1_dat <= (rs1_q == '0) ? '0 : rf_rs1Out;
      op_rs2_dat <= (rs2_q == '0) ? '0 : rf_rs2Out;
`endif
    end
  end

  assign op_valid = op_valid_q;
endmodule
